preamble_sfd_detect: RTL and testbench

Parametrised preamble and SFD detector for the 802.11b 1 Mbps DSSS receive chain. It sits after the descrambler, consumes one qualified data bit per data_valid strobe, and qualifies a run of descrambled ones (SYNC field) with a configurable threshold and error tolerance. It then searches for a configurable 16-bit SFD within a bounded window and reports detection, lock and timeout to the PLCP header parser.

---
 rtl/preamble_sfd_detect.sv | 156 +++++++++++++++
 tb/tb_preamble_sfd_detect.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/preamble_sfd_detect.sv
// Preamble (SYNC ones run) and SFD detector for the 802.11b 1 Mbps DSSS receive path.
// Qualifies a run of descrambled ones, then searches a bounded window for the LSB-first SFD.
module preamble_sfd_detect #(
  parameter int          ONES_THRESHOLD = 32,
  parameter int          SYNC_ERR_TOL   = 0,
  parameter logic [15:0] SFD_PATTERN    = 16'hF3A0,
  parameter int          SFD_TIMEOUT    = 128,
  parameter int          CNT_W          = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_bit,
  input  logic data_valid,
  input  logic clear,
  output logic preamble_detected,
  output logic sfd_detected,
  output logic sfd_timeout,
  output logic locked
);

  localparam logic [CNT_W-1:0] ONES_TH = CNT_W'(ONES_THRESHOLD);
  localparam logic [CNT_W-1:0] ERR_TOL = CNT_W'(SYNC_ERR_TOL);
  localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(SFD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SYNC       = 2'd1,
    SFD_SEARCH = 2'd2,
    LOCKED     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [15:0]      sfd_sr_q, sfd_sr_d;
  logic             pre_q, pre_d;
  logic             sfd_q, sfd_d;
  logic             tmo_q, tmo_d;
  logic             locked_q, locked_d;

  logic [CNT_W-1:0] ones_inc, err_inc, win_inc;
  logic [15:0]      sr_shift;

  assign ones_inc = ones_cnt_q + CNT_ONE;
  assign err_inc  = err_cnt_q + CNT_ONE;
  assign win_inc  = win_cnt_q + CNT_ONE;
  assign sr_shift = {data_bit, sfd_sr_q[15:1]};

  always_comb begin
    state_d    = state_q;
    ones_cnt_d = ones_cnt_q;
    err_cnt_d  = err_cnt_q;
    win_cnt_d  = win_cnt_q;
    sfd_sr_d   = sfd_sr_q;
    pre_d      = 1'b0;
    sfd_d      = 1'b0;
    tmo_d      = 1'b0;
    locked_d   = locked_q;

    if (clear) begin
      state_d    = IDLE;
      ones_cnt_d = '0;
      err_cnt_d  = '0;
      win_cnt_d  = '0;
      sfd_sr_d   = '0;
      locked_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_valid && data_bit) begin
            state_d    = SYNC;
            ones_cnt_d = CNT_ONE;
            err_cnt_d  = '0;
          end
        end
        SYNC: begin
          if (data_valid) begin
            if (data_bit) begin
              ones_cnt_d = ones_inc;
              if (ones_inc == ONES_TH) begin
                state_d   = SFD_SEARCH;
                pre_d     = 1'b1;
                sfd_sr_d  = 16'hFFFF;
                win_cnt_d = '0;
              end
            end else begin
              // Zeros accumulate across the run; only exceeding the tolerance restarts it.
              err_cnt_d = err_inc;
              if (err_inc > ERR_TOL) begin
                state_d    = IDLE;
                ones_cnt_d = '0;
                err_cnt_d  = '0;
                win_cnt_d  = '0;
              end
            end
          end
        end
        SFD_SEARCH: begin
          if (data_valid) begin
            sfd_sr_d  = sr_shift;
            win_cnt_d = win_inc;
            if (sr_shift == SFD_PATTERN) begin
              state_d  = LOCKED;
              sfd_d    = 1'b1;
              locked_d = 1'b1;
            end else if (win_inc == WIN_MAX) begin
              state_d    = IDLE;
              tmo_d      = 1'b1;
              ones_cnt_d = '0;
              err_cnt_d  = '0;
              win_cnt_d  = '0;
            end
          end
        end
        LOCKED: begin
          locked_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ones_cnt_q <= '0;
      err_cnt_q  <= '0;
      win_cnt_q  <= '0;
      sfd_sr_q   <= 16'hFFFF;
      pre_q      <= 1'b0;
      sfd_q      <= 1'b0;
      tmo_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_cnt_q <= ones_cnt_d;
      err_cnt_q  <= err_cnt_d;
      win_cnt_q  <= win_cnt_d;
      sfd_sr_q   <= sfd_sr_d;
      pre_q      <= pre_d;
      sfd_q      <= sfd_d;
      tmo_q      <= tmo_d;
      locked_q   <= locked_d;
    end
  end

  assign preamble_detected = pre_q;
  assign sfd_detected      = sfd_q;
  assign sfd_timeout       = tmo_q;
  assign locked            = locked_q;

endmodule

// File: tb/tb_preamble_sfd_detect.sv
// Directed bench for preamble_sfd_detect: default instance plus a SYNC_ERR_TOL=2 instance.
// Expected output vectors {preamble, sfd, timeout, locked} are queued per strobe and checked after the edge.
module tb_preamble_sfd_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, data_bit, dv, clear, sel;
  logic dv_def, dv_tol;
  logic d_pre, d_sfd, d_tmo, d_lock;
  logic t_pre, t_sfd, t_tmo, t_lock;
  logic [3:0] obs;

  assign dv_def = dv & ~sel;
  assign dv_tol = dv & sel;
  assign obs    = sel ? {t_pre, t_sfd, t_tmo, t_lock} : {d_pre, d_sfd, d_tmo, d_lock};

  preamble_sfd_detect u_def (
    .clk               (clk),
    .reset_n           (reset_n),
    .data_bit          (data_bit),
    .data_valid        (dv_def),
    .clear             (clear),
    .preamble_detected (d_pre),
    .sfd_detected      (d_sfd),
    .sfd_timeout       (d_tmo),
    .locked            (d_lock)
  );

  preamble_sfd_detect #(.SYNC_ERR_TOL(2)) u_tol (
    .clk               (clk),
    .reset_n           (reset_n),
    .data_bit          (data_bit),
    .data_valid        (dv_tol),
    .clear             (clear),
    .preamble_detected (t_pre),
    .sfd_detected      (t_sfd),
    .sfd_timeout       (t_tmo),
    .locked            (t_lock)
  );

  typedef struct {
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          gap    = 0;
  logic [15:0] sfd_v  = 16'hF3A0;

  task automatic check(input string tag, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One strobe; expected vector is queued at drive time and popped after the sampling edge.
  task automatic send(input logic b, input logic [3:0] exp, input string tag, input logic clr);
    exp_t e;
    e.tag = tag;
    e.v   = exp;
    sb.push_back(e);
    @(negedge clk);
    data_bit = b;
    dv       = 1'b1;
    clear    = clr;
    @(posedge clk);
    #1;
    dv    = 1'b0;
    clear = 1'b0;
    e = sb.pop_front();
    check(e.tag, e.v);
    repeat (gap) begin
      @(posedge clk);
      #1;
      check({e.tag, "_gap"}, {3'b000, e.v[0]});
    end
  endtask

  task automatic ones(input int n, input int pulse_at, input string tag);
    for (int i = 1; i <= n; i++)
      send(1'b1, (i == pulse_at) ? 4'b1000 : 4'b0000, tag, 1'b0);
  endtask

  task automatic sfd(input string tag);
    for (int i = 0; i < 16; i++)
      send(sfd_v[i], (i == 15) ? 4'b0101 : 4'b0000, tag, 1'b0);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check(tag, 4'b0000);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    check(tag, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_nominal(input string tag);
    ones(40, 32, {tag, "_pre"});
    sfd({tag, "_sfd"});
    for (int i = 0; i < 16; i++)
      send(sfd_v[i], 4'b0001, {tag, "_lk_hold"}, 1'b0);
    do_clear({tag, "_clear"});
  endtask

  initial begin
    reset_n  = 1'b0;
    data_bit = 1'b0;
    dv       = 1'b0;
    clear    = 1'b0;
    sel      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_def", 4'b0000);
    sel = 1'b1;
    #1;
    check("reset_tol", 4'b0000);
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Nominal preamble + SFD, back-to-back and with an 11-cycle strobe period
    gap = 0;
    run_nominal("s1_b2b");
    gap = 10;
    run_nominal("s1_sp11");
    gap = 0;

    // Zero tolerance: a single zero restarts the run
    ones(20, 0, "s2_first");
    send(1'b0, 4'b0000, "s2_zero", 1'b0);
    ones(40, 32, "s2_restart");
    do_clear("s2_clear");

    // Tolerance of two zeros, then a run with three zeros
    sel = 1'b1;
    ones(10, 0, "s3a_run1");
    send(1'b0, 4'b0000, "s3a_z1", 1'b0);
    ones(10, 0, "s3a_run2");
    send(1'b0, 4'b0000, "s3a_z2", 1'b0);
    ones(12, 12, "s3a_run3");
    sfd("s3a_sfd");
    do_clear("s3a_clear");
    ones(10, 0, "s3b_run1");
    send(1'b0, 4'b0000, "s3b_z1", 1'b0);
    ones(10, 0, "s3b_run2");
    send(1'b0, 4'b0000, "s3b_z2", 1'b0);
    ones(5, 0, "s3b_run3");
    send(1'b0, 4'b0000, "s3b_z3", 1'b0);
    ones(32, 32, "s3b_restart");
    do_clear("s3b_clear");
    sel = 1'b0;

    // 8 trailing ones + 120 alternating bits = 128 search bits, then recovery
    ones(40, 32, "s4_pre");
    for (int i = 1; i <= 120; i++)
      send((i % 2 == 1) ? 1'b1 : 1'b0, (i == 120) ? 4'b0010 : 4'b0000, "s4_search", 1'b0);
    ones(32, 32, "s4_again");
    sfd("s4_sfd");
    do_clear("s4_clear");

    // clear coincident with the final SFD strobe
    ones(32, 32, "s5_pre");
    for (int i = 0; i < 15; i++)
      send(sfd_v[i], 4'b0000, "s5_sfd", 1'b0);
    send(sfd_v[15], 4'b0000, "s5_clr_last", 1'b1);
    ones(32, 32, "s5_idle");
    do_clear("s5_clear");

    // Asynchronous reset mid-SYNC, during a pulse, and while locked
    ones(10, 0, "s6_sync");
    async_reset("s6_rst_sync");
    ones(32, 32, "s6_pre1");
    async_reset("s6_rst_pulse");
    ones(32, 32, "s6_pre2");
    sfd("s6_sfd2");
    async_reset("s6_rst_locked");
    ones(32, 32, "s6_pre3");
    sfd("s6_sfd3");
    do_clear("s6_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
